// File: rtl/yuv_rgb_pkg.sv
// ---------------------------------------------------------------------------
// yuv_rgb_pkg
// Shared definitions for the YUV->RGB frame sequencer:
//   state_e        sequencer state encoding
//   CH_R/CH_G/CH_B RGB channel select codes driven on ch_sel
//   RT_Y/RT_U/RT_V read-type codes carried by the read-latency pipe
//   is_chroma_pix  true when the current pixel fetches its own U/V samples
// ---------------------------------------------------------------------------
package yuv_rgb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_Y = 3'd1,
    ST_RD_U = 3'd2,
    ST_RD_V = 3'd3,
    ST_WAIT = 3'd4,
    ST_WR   = 3'd5,
    ST_DONE = 3'd6
  } state_e;

  localparam logic [1:0] CH_R = 2'd0;
  localparam logic [1:0] CH_G = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;

  localparam logic [1:0] RT_Y = 2'd0;
  localparam logic [1:0] RT_U = 2'd1;
  localparam logic [1:0] RT_V = 2'd2;

  // In 4:2:2 only even pixels fetch chroma; odd pixels reuse the held pair.
  function automatic logic is_chroma_pix(input logic mode_422, input logic p_lsb);
    return (!mode_422) || (!p_lsb);
  endfunction

endpackage

// File: rtl/rd_lat_pipe.sv
// ---------------------------------------------------------------------------
// rd_lat_pipe
// RD_LAT-deep delay line carrying {valid, read type}. The input is the
// *next-cycle* read request, so stage 0 lines up with the registered rd_en
// and the ld strobes (one more register) fire exactly RD_LAT cycles after it.
// Ports:
//   clk, rst          clock, synchronous active-high reset (flushes pipe)
//   rd_vld_nxt        a read will be issued in the next cycle
//   rd_type_nxt       RT_Y/RT_U/RT_V of that read
//   ld_y, ld_u, ld_v  registered capture strobes for the datapath
// ---------------------------------------------------------------------------
module rd_lat_pipe
  import yuv_rgb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rd_vld_nxt,
  input  logic [1:0] rd_type_nxt,
  output logic       ld_y,
  output logic       ld_u,
  output logic       ld_v
);

  logic [RD_LAT-1:0][2:0] stage_q, stage_d;
  logic                   ld_y_q, ld_y_d;
  logic                   ld_u_q, ld_u_d;
  logic                   ld_v_q, ld_v_d;

  // Shift the pipe and decode the oldest stage into the strobe registers.
  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = {rd_vld_nxt, rd_type_nxt};
    for (int i = 1; i < RD_LAT; i++) begin
      stage_d[i] = stage_q[i-1];
    end
    ld_y_d = 1'b0;
    ld_u_d = 1'b0;
    ld_v_d = 1'b0;
    if (stage_q[RD_LAT-1][2]) begin
      case (stage_q[RD_LAT-1][1:0])
        RT_Y:    ld_y_d = 1'b1;
        RT_U:    ld_u_d = 1'b1;
        RT_V:    ld_v_d = 1'b1;
        default: ld_y_d = 1'b0;
      endcase
    end else begin
      ld_y_d = 1'b0;
    end
  end

  // Pipe and strobe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
      ld_y_q  <= 1'b0;
      ld_u_q  <= 1'b0;
      ld_v_q  <= 1'b0;
    end else begin
      stage_q <= stage_d;
      ld_y_q  <= ld_y_d;
      ld_u_q  <= ld_u_d;
      ld_v_q  <= ld_v_d;
    end
  end

  assign ld_y = ld_y_q;
  assign ld_u = ld_u_q;
  assign ld_v = ld_v_q;

endmodule

// File: rtl/yuv_rgb_frame_sequencer.sv
// ---------------------------------------------------------------------------
// yuv_rgb_frame_sequencer
// Walks pix_count pixels through Y/U/V planar reads and interleaved RGB
// writes, generating memory strobes/addresses and datapath capture strobes.
// Optional macro YUV_RGB_PERF_CNT_EN enables the busy-cycle counter that
// feeds cycles_last; without it cycles_last is tied to zero.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   start, mode_422, pix_count      launch request and run setup (latched)
//   y/u/v/rgb_base                  plane base addresses (latched)
//   rd_en, rd_addr                  memory read port
//   ld_y, ld_u, ld_v                capture strobes, RD_LAT after each read
//   wr_en, wr_addr, ch_sel          memory write port and channel (R/G/B)
//   busy, done                      run status; done pulses at end of frame
//   cycles_last                     busy cycles of the last completed run
// All outputs come straight from flops: next-cycle values are decoded from
// the next state so each output lines up with the state it belongs to.
// ---------------------------------------------------------------------------
module yuv_rgb_frame_sequencer
  import yuv_rgb_pkg::*;
#(
  parameter int ADDR_W = 18,
  parameter int CNT_W  = 17,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode_422,
  input  logic [CNT_W-1:0]  pix_count,
  input  logic [ADDR_W-1:0] y_base,
  input  logic [ADDR_W-1:0] u_base,
  input  logic [ADDR_W-1:0] v_base,
  input  logic [ADDR_W-1:0] rgb_base,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              ld_y,
  output logic              ld_u,
  output logic              ld_v,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [1:0]        ch_sel,
  output logic              busy,
  output logic              done,
  output logic [31:0]       cycles_last
);

  localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  p_q, p_d, pcnt_q, pcnt_d;
  logic [ADDR_W-1:0] wp_q, wp_d;
  logic [1:0]        wait_cnt_q, wait_cnt_d;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] y_base_q, y_base_d, u_base_q, u_base_d, v_base_q, v_base_d;
  logic              rd_en_q, rd_en_d, wr_en_q, wr_en_d, busy_q, busy_d, done_q, done_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [1:0]        ch_sel_q, ch_sel_d, rt_d;
  logic [CNT_W-1:0]  p_inc_s, chroma_idx_s;

  // Next-state logic, then output decode from the next state.
  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    pcnt_d     = pcnt_q;
    wp_d       = wp_q;
    wait_cnt_d = wait_cnt_q;
    mode_d     = mode_q;
    y_base_d   = y_base_q;
    u_base_d   = u_base_q;
    v_base_d   = v_base_q;
    ch_sel_d   = CH_R;
    p_inc_s    = p_q + CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d   = mode_422;
          pcnt_d   = pix_count;
          y_base_d = y_base;
          u_base_d = u_base;
          v_base_d = v_base;
          wp_d     = rgb_base;
          p_d      = {CNT_W{1'b0}};
          if (pix_count == {CNT_W{1'b0}}) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RD_Y;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_Y: begin
        if (is_chroma_pix(mode_q, p_q[0])) begin
          state_d = ST_RD_U;
        end else begin
          state_d    = ST_WAIT;
          wait_cnt_d = 2'd0;
        end
      end
      ST_RD_U: state_d = ST_RD_V;
      ST_RD_V: begin
        state_d    = ST_WAIT;
        wait_cnt_d = 2'd0;
      end
      ST_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          state_d = ST_WR;
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end
      ST_WR: begin
        // ch_sel_q doubles as the write-phase counter.
        case (ch_sel_q)
          CH_R: ch_sel_d = CH_G;
          CH_G: ch_sel_d = CH_B;
          default: begin
            p_d = p_inc_s;
            if (p_inc_s == pcnt_q) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_RD_Y;
            end
          end
        endcase
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    chroma_idx_s = mode_d ? (p_d >> 1) : p_d;
    rd_en_d      = 1'b0;
    rd_addr_d    = {ADDR_W{1'b0}};
    rt_d         = RT_Y;
    wr_en_d      = 1'b0;
    wr_addr_d    = {ADDR_W{1'b0}};
    case (state_d)
      ST_RD_Y: begin
        rd_en_d   = 1'b1;
        rd_addr_d = y_base_d + ADDR_W'(p_d);
        rt_d      = RT_Y;
      end
      ST_RD_U: begin
        rd_en_d   = 1'b1;
        rd_addr_d = u_base_d + ADDR_W'(chroma_idx_s);
        rt_d      = RT_U;
      end
      ST_RD_V: begin
        rd_en_d   = 1'b1;
        rd_addr_d = v_base_d + ADDR_W'(chroma_idx_s);
        rt_d      = RT_V;
      end
      ST_WR: begin
        // wp_q always points at the next RGB byte to write; wraps silently.
        wr_en_d   = 1'b1;
        wr_addr_d = wp_q;
        wp_d      = wp_q + ADDR_W'(1);
      end
      default: rd_en_d = 1'b0;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State, run context and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      p_q        <= {CNT_W{1'b0}};
      pcnt_q     <= {CNT_W{1'b0}};
      wp_q       <= {ADDR_W{1'b0}};
      wait_cnt_q <= 2'd0;
      mode_q     <= 1'b0;
      y_base_q   <= {ADDR_W{1'b0}};
      u_base_q   <= {ADDR_W{1'b0}};
      v_base_q   <= {ADDR_W{1'b0}};
      rd_en_q    <= 1'b0;
      rd_addr_q  <= {ADDR_W{1'b0}};
      wr_en_q    <= 1'b0;
      wr_addr_q  <= {ADDR_W{1'b0}};
      ch_sel_q   <= CH_R;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      p_q        <= p_d;
      pcnt_q     <= pcnt_d;
      wp_q       <= wp_d;
      wait_cnt_q <= wait_cnt_d;
      mode_q     <= mode_d;
      y_base_q   <= y_base_d;
      u_base_q   <= u_base_d;
      v_base_q   <= v_base_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      ch_sel_q   <= ch_sel_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  rd_lat_pipe #(.RD_LAT(RD_LAT)) u_rd_lat_pipe (
    .clk         (clk),
    .rst         (rst),
    .rd_vld_nxt  (rd_en_d),
    .rd_type_nxt (rt_d),
    .ld_y        (ld_y),
    .ld_u        (ld_u),
    .ld_v        (ld_v)
  );

`ifdef YUV_RGB_PERF_CNT_EN
  logic [31:0] perf_q, perf_d, perf_inc_s, cyc_last_q, cyc_last_d;

  // Busy-cycle counter; the DONE cycle itself is included in the snapshot.
  always_comb begin
    perf_inc_s = (perf_q == 32'hFFFF_FFFF) ? perf_q : (perf_q + 32'd1);
    perf_d     = perf_q;
    cyc_last_d = cyc_last_q;
    if ((state_q == ST_IDLE) && start) begin
      perf_d = 32'd0;
    end else if (busy_q) begin
      perf_d = perf_inc_s;
    end else begin
      perf_d = perf_q;
    end
    if (state_q == ST_DONE) begin
      cyc_last_d = perf_inc_s;
    end else begin
      cyc_last_d = cyc_last_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q     <= 32'd0;
      cyc_last_q <= 32'd0;
    end else begin
      perf_q     <= perf_d;
      cyc_last_q <= cyc_last_d;
    end
  end

  assign cycles_last = cyc_last_q;
`else
  assign cycles_last = 32'd0;
`endif

  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign ch_sel  = ch_sel_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_yuv_rgb_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_yuv_rgb_frame_sequencer
// Two instances (RD_LAT=1 and RD_LAT=3) share stimulus. For each run the
// bench builds the expected per-cycle output vector of every instance from
// its own timing model, queues it at start, and pops/compares one entry per
// cycle, #1 after the rising edge.
// ---------------------------------------------------------------------------
module tb_yuv_rgb_frame_sequencer;

  localparam int AW = 18;
  localparam int CW = 17;

  logic          clk = 1'b0;
  logic          rst, start, mode_422;
  logic [CW-1:0] pix_count;
  logic [AW-1:0] y_base, u_base, v_base, rgb_base;

  logic          rd_en1, ld_y1, ld_u1, ld_v1, wr_en1, busy1, done1;
  logic [AW-1:0] rd_addr1, wr_addr1;
  logic [1:0]    ch_sel1;
  logic [31:0]   cl1;
  logic          rd_en3, ld_y3, ld_u3, ld_v3, wr_en3, busy3, done3;
  logic [AW-1:0] rd_addr3, wr_addr3;
  logic [1:0]    ch_sel3;
  logic [31:0]   cl3;

  logic [63:0] obs1, obs3;
  logic [63:0] q1[$];
  logic [63:0] q3[$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  yuv_rgb_frame_sequencer #(.ADDR_W(AW), .CNT_W(CW), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .mode_422(mode_422), .pix_count(pix_count),
    .y_base(y_base), .u_base(u_base), .v_base(v_base), .rgb_base(rgb_base),
    .rd_en(rd_en1), .rd_addr(rd_addr1), .ld_y(ld_y1), .ld_u(ld_u1), .ld_v(ld_v1),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .ch_sel(ch_sel1), .busy(busy1), .done(done1),
    .cycles_last(cl1));

  yuv_rgb_frame_sequencer #(.ADDR_W(AW), .CNT_W(CW), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .mode_422(mode_422), .pix_count(pix_count),
    .y_base(y_base), .u_base(u_base), .v_base(v_base), .rgb_base(rgb_base),
    .rd_en(rd_en3), .rd_addr(rd_addr3), .ld_y(ld_y3), .ld_u(ld_u3), .ld_v(ld_v3),
    .wr_en(wr_en3), .wr_addr(wr_addr3), .ch_sel(ch_sel3), .busy(busy3), .done(done3),
    .cycles_last(cl3));

  assign obs1 = {19'd0, rd_en1, rd_addr1, ld_y1, ld_u1, ld_v1, wr_en1, wr_addr1, ch_sel1, busy1, done1};
  assign obs3 = {19'd0, rd_en3, rd_addr3, ld_y3, ld_u3, ld_v3, wr_en3, wr_addr3, ch_sel3, busy3, done3};

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected output vectors for cycles 1..done+1 after start is sampled.
  task automatic build(input int lat, input bit m, input int n, output int done_idx);
    logic          e_rd[512], e_ly[512], e_lu[512], e_lv[512], e_wr[512], e_bs[512], e_dn[512];
    logic [AW-1:0] e_ra[512], e_wa[512];
    logic [1:0]    e_ch[512];
    logic [AW-1:0] wp, pa;
    bit            chroma;
    int            t;
    for (int k = 0; k < 512; k++) begin
      e_rd[k] = 1'b0; e_ly[k] = 1'b0; e_lu[k] = 1'b0; e_lv[k] = 1'b0; e_wr[k] = 1'b0;
      e_bs[k] = 1'b0; e_dn[k] = 1'b0; e_ra[k] = '0; e_wa[k] = '0; e_ch[k] = 2'd0;
    end
    t  = 1;
    wp = rgb_base;
    for (int p = 0; p < n; p++) begin
      chroma = !m || (p % 2 == 0);
      pa = m ? AW'(p / 2) : AW'(p);
      e_rd[t] = 1'b1; e_ra[t] = y_base + AW'(p); e_ly[t+lat] = 1'b1;
      if (chroma) begin
        e_rd[t+1] = 1'b1; e_ra[t+1] = u_base + pa; e_lu[t+1+lat] = 1'b1;
        e_rd[t+2] = 1'b1; e_ra[t+2] = v_base + pa; e_lv[t+2+lat] = 1'b1;
        t += 3;
      end else begin
        t += 1;
      end
      t += lat;
      for (int c = 0; c < 3; c++) begin
        e_wr[t] = 1'b1; e_wa[t] = wp; e_ch[t] = 2'(c);
        wp = wp + AW'(1);
        t++;
      end
    end
    e_dn[t]  = 1'b1;
    done_idx = t;
    for (int k = 1; k <= t; k++) e_bs[k] = 1'b1;
    for (int k = 1; k <= t + 1; k++) begin
      if (lat == 1)
        q1.push_back({19'd0, e_rd[k], e_ra[k], e_ly[k], e_lu[k], e_lv[k], e_wr[k], e_wa[k], e_ch[k], e_bs[k], e_dn[k]});
      else
        q3.push_back({19'd0, e_rd[k], e_ra[k], e_ly[k], e_lu[k], e_lv[k], e_wr[k], e_wa[k], e_ch[k], e_bs[k], e_dn[k]});
    end
  endtask

  // One run: rst_at/st_at (cycle index, -1 = never) inject reset / a stray start.
  task automatic run(input string name, input bit m, input int n, input int rst_at, input int st_at);
    int d1, d3, cyc;
    logic [31:0] ecl1, ecl3;
    mode_422  = m;
    pix_count = CW'(n);
    build(1, m, n, d1);
    build(3, m, n, d3);
`ifdef YUV_RGB_PERF_CNT_EN
    ecl1 = 32'(d1);
    ecl3 = 32'(d3);
`else
    ecl1 = 32'd0;
    ecl3 = 32'd0;
`endif
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (q1.size() > 0 || q3.size() > 0) begin
      if (q1.size() > 0) check_eq($sformatf("%s_lat1_c%0d", name, cyc), obs1, q1.pop_front());
      if (q3.size() > 0) check_eq($sformatf("%s_lat3_c%0d", name, cyc), obs3, q3.pop_front());
      if (cyc == st_at) begin
        start     = 1'b1;
        pix_count = CW'(1);
      end else begin
        start = 1'b0;
      end
      if (cyc == rst_at) begin
        rst = 1'b1;
        q1.delete(); q3.delete();
        repeat (2) begin q1.push_back(64'd0); q3.push_back(64'd0); end
        ecl1 = 32'd0; ecl3 = 32'd0;
      end else begin
        rst = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      if (cyc > 2000) begin
        check_eq({name, "_timeout"}, 64'(cyc), 64'd2000);
        q1.delete(); q3.delete();
      end
    end
    rst   = 1'b0;
    start = 1'b0;
    check_eq({name, "_cycles_last1"}, {32'd0, cl1}, {32'd0, ecl1});
    check_eq({name, "_cycles_last3"}, {32'd0, cl3}, {32'd0, ecl3});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode_422 = 1'b0; pix_count = '0;
    y_base = '0; u_base = '0; v_base = '0; rgb_base = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_lat1", obs1, 64'd0);
    check_eq("reset_lat3", obs3, 64'd0);
    check_eq("reset_cl", {cl1, cl3}, 64'd0);
    // rst and start together: reset wins, nothing launches.
    y_base = 18'h100; u_base = 18'h200; v_base = 18'h300; rgb_base = 18'h400;
    pix_count = 17'd1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check_eq("rst_start_lat1", obs1, 64'd0);
    @(posedge clk); #1;
    check_eq("rst_start_idle1", obs1, 64'd0);
    check_eq("rst_start_idle3", obs3, 64'd0);

    run("s444_n1", 1'b0, 1, -1, -1);
    run("s422_n2", 1'b1, 2, -1, -1);
    run("s_n0", 1'b0, 0, -1, -1);
    run("s422_n3", 1'b1, 3, -1, -1);
    run("s444_n4", 1'b0, 4, -1, -1);
    run("s_rst", 1'b0, 10, 45, 20);
    rgb_base = 18'h3FFFE;
    run("s_wrap", 1'b0, 1, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/yuv_rgb_frame_sequencer.md
Name: yuv_rgb_frame_sequencer

Overview:
- Parametrised successor to the fixed-sequence YUV→RGB controller.
- Generates all memory addresses and datapath strobes to convert `pix_count` pixels from Y/U/V planes into an interleaved RGB buffer.
- Runtime mode: 4:4:4, or 4:2:2 (chroma shared by pixel pairs).
- Parametrised memory read latency.
- Sits between the single-port pixel memory and the external YUV→RGB arithmetic datapath.

Parameters:
- ADDR_W, 18: memory address width.
- CNT_W, 17: pixel counter width.
- RD_LAT, 1: memory read latency in cycles; legal range 1..4.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  launch request; honoured only in IDLE.
- mode_422  in  1  1 = 4:2:2, 0 = 4:4:4; latched at start.
- pix_count  in  CNT_W  number of pixels to convert; latched at start.
- y_base, u_base, v_base, rgb_base  in  ADDR_W each  plane base addresses; latched at start.
- rd_en  out  1  memory read strobe.
- rd_addr  out  ADDR_W  memory read address.
- ld_y, ld_u, ld_v  out  1  datapath capture strobes, aligned with returning read data.
- wr_en  out  1  memory write strobe.
- wr_addr  out  ADDR_W  RGB write address.
- ch_sel  out  2  channel being written: 0 = R, 1 = G, 2 = B.
- busy  out  1  high from the first RD cycle through the DONE cycle.
- done  out  1  one-cycle pulse at end of frame.
- cycles_last  out  32  cycle count of the last completed run (see Optional Feature).

Behaviour:
- Reset: state IDLE; all outputs 0; pixel index p = 0; write pointer = 0; ld delay pipe flushed.
- Reset mid-run: aborts immediately; no done pulse; no further rd_en/wr_en.
- All outputs are registered (Moore).
- States: IDLE, RD_Y, RD_U, RD_V, WAIT, WR, DONE.
- IDLE:
  - start=1 → latch inputs, p=0.
  - If pix_count==0 → DONE; else → RD_Y.
  - start while busy is ignored.
- chroma_pix = !mode_422 || p[0]==0.
- RD_Y: rd_en=1, rd_addr = y_base+p.
  - Next state: RD_U if chroma_pix, else WAIT.
- RD_U: rd_en=1, rd_addr = u_base + (mode_422 ? p>>1 : p). Next state RD_V.
- RD_V: same address rule with v_base. Next state WAIT.
- ld strobes:
  - ld_y/ld_u/ld_v assert exactly RD_LAT cycles after the corresponding rd_en cycle.
  - Implemented as an RD_LAT-deep delay pipe keyed by read type.
- 4:2:2 odd pixel: no ld_u/ld_v; the datapath reuses the held chroma.
- WAIT: lasts exactly RD_LAT cycles, then WR.
- WR: 3 consecutive cycles.
  - wr_en=1, ch_sel = 0, 1, 2.
  - wr_addr = rgb_base + 3p + ch_sel, from an incrementing pointer.
  - On the third cycle: p++; if p == pix_count → DONE, else → RD_Y.
- DONE: done=1 for one cycle, busy=1, then IDLE.
- Per-pixel cost:
  - Chroma pixel: 3 + RD_LAT + 3 cycles.
  - Non-chroma pixel: 1 + RD_LAT + 3 cycles.
- Arithmetic: all address sums are modulo 2^ADDR_W; wrap is silent.
- Odd pix_count in 4:2:2: the last pixel has even index, so it reads chroma normally.
- start and rst asserted together: rst wins.

Optional Feature:
- Macro: YUV_RGB_PERF_CNT_EN.
- Defined:
  - 32-bit counter clears on an accepted start and increments every busy cycle.
  - Copied to cycles_last in the DONE cycle; saturates at 0xFFFFFFFF.
  - Reset clears it.
- Undefined: cycles_last tied to 0; no counter logic.

Decomposition:
- Package yuv_rgb_pkg:
  - State encoding constants.
  - CH_R=0, CH_G=1, CH_B=2.
  - Read-type codes RT_Y/RT_U/RT_V.
- Sub-module rd_lat_pipe:
  - Parametrised RD_LAT delay line carrying {valid, read type}.
  - Decodes to ld_y/ld_u/ld_v.

Test Plan:
1. 4:4:4, RD_LAT=1, pix_count=1, bases Y=0x100/U=0x200/V=0x300/RGB=0x400, start sampled at cycle 0:
   - rd_addr 0x100, 0x200, 0x300 in cycles 1–3.
   - ld_y/ld_u/ld_v in cycles 2–4.
   - wr_addr 0x400–0x402 with ch_sel 0/1/2 in cycles 5–7.
   - done in cycle 8; busy low in cycle 9.
2. 4:2:2, RD_LAT=1, pix_count=2, same bases:
   - Pixel 1: only rd_addr 0x101 in cycle 8, no ld_u/ld_v.
   - wr_addr 0x403–0x405 in cycles 10–12; done in cycle 13.
3. RD_LAT=3, 4:4:4, pix_count=1: WAIT lasts 3 cycles; ld_v coincides with the last WAIT cycle; done in cycle 10.
4. pix_count=0: done in cycle 1; no rd_en or wr_en ever asserted.
5. rst asserted during pixel 5 of 10, and start pulsed mid-run:
   - After rst: outputs 0 next cycle, no done, state IDLE.
   - Mid-run start: no effect.
6. rgb_base=2^ADDR_W−2, pix_count=1: wr_addr wraps through 2^ADDR_W−2, 2^ADDR_W−1, 0.
   - With YUV_RGB_PERF_CNT_EN and scenario 1 timing: cycles_last=8.
